dmem_arbiter_rv32i: RTL and testbench
=====================================

# dmem_arbiter_rv32i

Arbiter that shares the single-port RV32I data memory between the CPU load/store path and a DMA/debug requester. It sits directly in front of the DMEM: the CPU has combinational priority so single-cycle loads/stores proceed unchanged, and DMA accesses fill idle cycles. Read data for DMA is registered with a valid strobe. An optional starvation guard forces a DMA slot and stalls the CPU for one cycle.

## Interface
- STARVE_LIMIT, 8: consecutive denied DMA cycles before a forced DMA slot (guard only; range 1..255)
- clock  in  1  system clock; DMEM writes on its falling edge
- reset_n  in  1  asynchronous active-low reset
- cpu_req  in  1  CPU accesses DMEM this cycle (load or store)
- cpu_store  in  1  CPU write enable
- cpu_storetype  in  2  00=SW, 01=SH, 10=SB, 11=none
- cpu_addr  in  32  CPU byte address
- cpu_wdata  in  32  CPU store data (rs2)
- cpu_stall  out  1  CPU must hold its instruction this cycle
- cpu_rdata  out  32  DMEM read data to CPU (combinational pass-through)
- dma_req  in  1  DMA request; held with its fields stable until dma_gnt
- dma_we  in  1  DMA write (word only)
- dma_addr  in  32  DMA byte address; bits [1:0] ignored
- dma_wdata  in  32  DMA write word
- dma_gnt  out  1  DMA access performed this cycle
- dma_rdata  out  32  registered DMA read word
- dma_rvalid  out  1  one-cycle pulse, dma_rdata valid
- mem_store  out  1  DMEM write enable
- mem_storetype  out  2  DMEM store type
- mem_addr  out  32  DMEM byte address
- mem_wdata  out  32  DMEM write data
- mem_rdata  in  32  DMEM asynchronous read data

## Operation
- Owner selection (combinational, each cycle): FORCE state -> DMA; else cpu_req -> CPU; else dma_req -> DMA; else none.
- CPU owner: mem_* = cpu_*; mem_store = cpu_store.
- DMA owner: mem_addr = {dma_addr[31:2],2'b00}, mem_storetype = 00, mem_store = dma_we, mem_wdata = dma_wdata; dma_gnt = 1.
- No owner: mem_store = 0, mem_storetype = 11, mem_addr/mem_wdata = 0.
- cpu_rdata = mem_rdata always; meaningful only when CPU owns.
- DMA read granted (dma_we=0): dma_rdata <= mem_rdata at rising edge; dma_rvalid = 1 next cycle only. DMA write: no rvalid.
- FSM states: NORMAL, FORCE.
  - NORMAL: starve_cnt (8 bit) increments when dma_req && cpu_req; clears when dma_gnt or !dma_req. When starve_cnt reaches STARVE_LIMIT-1 and increments, next state FORCE, starve_cnt -> 0.
  - FORCE: cpu_stall = cpu_req; DMA owns regardless of cpu_req; one cycle; -> NORMAL. If dma_req dropped (protocol violation) FORCE still lasts one cycle, no access, no stall.
- cpu_stall = 0 in NORMAL.

## Timing
- Reset (reset_n low, any time incl. mid-access): state NORMAL, starve_cnt 0, dma_rdata 0, dma_rvalid 0; mem_store, dma_gnt, cpu_stall forced 0 while reset_n low.
- CPU path: zero latency, purely combinational; writes commit at falling edge of the granted cycle.
- DMA: dma_gnt same cycle as access; read latency 1 cycle (dma_rvalid at cycle after gnt); back-to-back grants give back-to-back rvalid.
- Worst-case DMA wait with guard: STARVE_LIMIT cycles of denial then grant on cycle STARVE_LIMIT+1.
- Simultaneous cpu_req and dma_req in NORMAL below limit: CPU wins, no stall.

## Configuration
- DMEM_ARB_STARVE_GUARD_EN defined: FSM, starve_cnt and cpu_stall behaviour as above.
- Not defined: no FSM or counter; strict CPU priority; cpu_stall tied 0; STARVE_LIMIT unused; DMA can starve indefinitely.

## Structure
- Shared package dmem_pkg: storetype constants (ST_SW=00, ST_SH=01, ST_SB=10, ST_NONE=11), FSM state encoding, owner encoding (NONE/CPU/DMA).
- One sub-module natural: dmem_starve_guard (counter + FSM, outputs force), instantiated only under the macro.

## Test plan
- Idle DMEM, DMA read addr 0x0000_0013 -> dma_gnt same cycle, mem_addr 0x10, dma_rvalid next cycle with dma_rdata = word at 0x10.
- CPU SB addr 0x21 data 0xAB with dma_req write pending -> mem_storetype 10, mem_addr 0x21, dma_gnt 0; DMA granted first cycle cpu_req drops.
- Guard on, STARVE_LIMIT=4, cpu_req and dma_req held high -> 4 CPU cycles, 5th cycle cpu_stall 1 and dma_gnt 1, then CPU resumes; counter restarts.
- Guard off, same stimulus for 100 cycles -> dma_gnt never 1, cpu_stall never 1.
- DMA write 0xDEADBEEF to 0x40, then DMA read 0x40 -> dma_rdata 0xDEADBEEF with rvalid.
- reset_n low during DMA read grant cycle -> dma_rvalid stays 0, dma_rdata 0, mem_store 0; after release state NORMAL.

Source files
------------

// File: rtl/dmem_pkg.sv
// Shared constants for the RV32I data-memory arbiter: store types, guard FSM
// state encoding and memory-owner encoding.
package dmem_pkg;

    localparam logic [1:0] ST_SW   = 2'b00;
    localparam logic [1:0] ST_SH   = 2'b01;
    localparam logic [1:0] ST_SB   = 2'b10;
    localparam logic [1:0] ST_NONE = 2'b11;

    typedef enum logic {
        GS_NORMAL = 1'b0,
        GS_FORCE  = 1'b1
    } guard_state_e;

    typedef enum logic [1:0] {
        OWN_NONE = 2'b00,
        OWN_CPU  = 2'b01,
        OWN_DMA  = 2'b10
    } owner_e;

    function automatic logic [31:0] word_align(input logic [31:0] addr);
        return {addr[31:2], 2'b00};
    endfunction

endpackage

// File: rtl/dmem_starve_guard.sv
// Starvation guard: counts consecutive cycles where the CPU blocks a pending DMA
// request and forces a single DMA slot once STARVE_LIMIT is reached.
//
// state     | meaning
// ----------+--------------------------------------------------------------
// GS_NORMAL | CPU has priority; starve_cnt tracks denied DMA cycles
// GS_FORCE  | one cycle where DMA owns DMEM and a requesting CPU is stalled
module dmem_starve_guard
    import dmem_pkg::*;
#(
    parameter int STARVE_LIMIT = 8
) (
    input  logic clock,
    input  logic reset_n,
    input  logic cpu_req,
    input  logic dma_req,
    input  logic dma_gnt,
    output logic force_dma
);

    localparam logic [7:0] LIMIT_M1 = 8'(STARVE_LIMIT - 1);

    guard_state_e state_q, state_d;
    logic [7:0]   starve_cnt_q, starve_cnt_d;
    logic         force_q, force_d;

    always_comb begin
        state_d      = state_q;
        starve_cnt_d = starve_cnt_q;
        case (state_q)
            GS_NORMAL: begin
                if (dma_gnt || !dma_req) begin
                    starve_cnt_d = 8'd0;
                end else if (cpu_req) begin
                    if (starve_cnt_q == LIMIT_M1) begin
                        state_d      = GS_FORCE;
                        starve_cnt_d = 8'd0;
                    end else begin
                        starve_cnt_d = starve_cnt_q + 8'd1;
                    end
                end
            end
            GS_FORCE: begin
                state_d      = GS_NORMAL;
                starve_cnt_d = 8'd0;
            end
            default: begin
                state_d      = GS_NORMAL;
                starve_cnt_d = 8'd0;
            end
        endcase
        force_d = (state_d == GS_FORCE);
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= GS_NORMAL;
            starve_cnt_q <= 8'd0;
            force_q      <= 1'b0;
        end else begin
            state_q      <= state_d;
            starve_cnt_q <= starve_cnt_d;
            force_q      <= force_d;
        end
    end

    assign force_dma = force_q;

endmodule

// File: rtl/dmem_arbiter_rv32i.sv
// Shares the single-port DMEM between the CPU load/store path (combinational
// priority) and a DMA/debug port. Starvation guard built when DMEM_ARB_STARVE_GUARD_EN is defined.
module dmem_arbiter_rv32i
    import dmem_pkg::*;
#(
    parameter int STARVE_LIMIT = 8
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic        cpu_req,
    input  logic        cpu_store,
    input  logic [1:0]  cpu_storetype,
    input  logic [31:0] cpu_addr,
    input  logic [31:0] cpu_wdata,
    output logic        cpu_stall,
    output logic [31:0] cpu_rdata,
    input  logic        dma_req,
    input  logic        dma_we,
    input  logic [31:0] dma_addr,
    input  logic [31:0] dma_wdata,
    output logic        dma_gnt,
    output logic [31:0] dma_rdata,
    output logic        dma_rvalid,
    output logic        mem_store,
    output logic [1:0]  mem_storetype,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata
);

    if (STARVE_LIMIT < 1 || STARVE_LIMIT > 255) begin : g_bad_limit
        $error("dmem_arbiter_rv32i: STARVE_LIMIT must be 1..255");
    end

    logic   force_dma;
    owner_e owner;

`ifdef DMEM_ARB_STARVE_GUARD_EN
    dmem_starve_guard #(
        .STARVE_LIMIT (STARVE_LIMIT)
    ) u_starve_guard (
        .clock     (clock),
        .reset_n   (reset_n),
        .cpu_req   (cpu_req),
        .dma_req   (dma_req),
        .dma_gnt   (dma_gnt),
        .force_dma (force_dma)
    );
`else
    assign force_dma = 1'b0;
`endif

    // A forced slot whose DMA request vanished hands the cycle back to the CPU,
    // so an unstalled CPU never loses its access.
    always_comb begin
        if (force_dma && dma_req) begin
            owner = OWN_DMA;
        end else if (cpu_req) begin
            owner = OWN_CPU;
        end else if (dma_req) begin
            owner = OWN_DMA;
        end else begin
            owner = OWN_NONE;
        end
    end

    always_comb begin
        mem_store     = 1'b0;
        mem_storetype = ST_NONE;
        mem_addr      = 32'd0;
        mem_wdata     = 32'd0;
        case (owner)
            OWN_CPU: begin
                mem_store     = cpu_store & reset_n;
                mem_storetype = cpu_storetype;
                mem_addr      = cpu_addr;
                mem_wdata     = cpu_wdata;
            end
            OWN_DMA: begin
                mem_store     = dma_we & reset_n;
                mem_storetype = ST_SW;
                mem_addr      = word_align(dma_addr);
                mem_wdata     = dma_wdata;
            end
            default: ;
        endcase
    end

    assign dma_gnt   = (owner == OWN_DMA) && reset_n;
    assign cpu_stall = force_dma && dma_req && cpu_req && reset_n;
    assign cpu_rdata = mem_rdata;

    logic [31:0] dma_rdata_q, dma_rdata_d;
    logic        dma_rvalid_q, dma_rvalid_d;

    always_comb begin
        dma_rvalid_d = dma_gnt && !dma_we;
        dma_rdata_d  = dma_rvalid_d ? mem_rdata : dma_rdata_q;
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            dma_rdata_q  <= 32'd0;
            dma_rvalid_q <= 1'b0;
        end else begin
            dma_rdata_q  <= dma_rdata_d;
            dma_rvalid_q <= dma_rvalid_d;
        end
    end

    assign dma_rdata  = dma_rdata_q;
    assign dma_rvalid = dma_rvalid_q;

endmodule

// File: tb/tb_dmem_arbiter_rv32i.sv
// Directed bench for dmem_arbiter_rv32i with a behavioural DMEM and a DMA
// read-data scoreboard; guard checks follow DMEM_ARB_STARVE_GUARD_EN.
module tb_dmem_arbiter_rv32i;

    localparam int LIMIT = 4;
`ifdef DMEM_ARB_STARVE_GUARD_EN
    localparam bit GUARD = 1'b1;
`else
    localparam bit GUARD = 1'b0;
`endif

    logic        clock = 1'b0;
    logic        reset_n;
    logic        cpu_req, cpu_store;
    logic [1:0]  cpu_storetype;
    logic [31:0] cpu_addr, cpu_wdata;
    logic        cpu_stall;
    logic [31:0] cpu_rdata;
    logic        dma_req, dma_we;
    logic [31:0] dma_addr, dma_wdata;
    logic        dma_gnt;
    logic [31:0] dma_rdata;
    logic        dma_rvalid;
    logic        mem_store;
    logic [1:0]  mem_storetype;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;

    int vectors = 0;
    int miscompares = 0;
    logic [31:0] exp_q[$];
    logic [31:0] mem [0:63];

    always #5 clock = ~clock;

    dmem_arbiter_rv32i #(.STARVE_LIMIT(LIMIT)) dut (
        .clock(clock), .reset_n(reset_n),
        .cpu_req(cpu_req), .cpu_store(cpu_store), .cpu_storetype(cpu_storetype),
        .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata), .cpu_stall(cpu_stall),
        .cpu_rdata(cpu_rdata),
        .dma_req(dma_req), .dma_we(dma_we), .dma_addr(dma_addr),
        .dma_wdata(dma_wdata), .dma_gnt(dma_gnt), .dma_rdata(dma_rdata),
        .dma_rvalid(dma_rvalid),
        .mem_store(mem_store), .mem_storetype(mem_storetype), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
    );

    // Behavioural single-port DMEM: async read, write on falling edge.
    assign mem_rdata = mem[mem_addr[7:2]];

    always @(negedge clock) begin
        if (mem_store) begin
            case (mem_storetype)
                2'b00: mem[mem_addr[7:2]] <= mem_wdata;
                2'b01: mem[mem_addr[7:2]][{mem_addr[1], 4'b0000} +: 16] <= mem_wdata[15:0];
                2'b10: mem[mem_addr[7:2]][{mem_addr[1:0], 3'b000} +: 8] <= mem_wdata[7:0];
                default: ;
            endcase
        end
    end

    always @(negedge clock) begin
        if (dma_rvalid) begin
            vectors++;
            if (exp_q.size() == 0) begin
                miscompares++;
                $display("FAIL rvalid_unexpected: dma_rdata=%h, no read outstanding", dma_rdata);
            end else begin
                logic [31:0] e;
                e = exp_q.pop_front();
                if (dma_rdata !== e) begin
                    miscompares++;
                    $display("FAIL dma_rdata: got %h expected %h", dma_rdata, e);
                end
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic drive_idle();
        cpu_req = 1'b0; cpu_store = 1'b0; cpu_storetype = 2'b11;
        cpu_addr = 32'd0; cpu_wdata = 32'd0;
        dma_req = 1'b0; dma_we = 1'b0; dma_addr = 32'd0; dma_wdata = 32'd0;
    endtask

    task automatic next_cycle();
        @(posedge clock);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < 64; i++) mem[i] = 32'h1000_0000 + 32'(i);
        drive_idle();
        reset_n = 1'b0;
        // Requests during reset must not reach DMEM.
        cpu_req = 1'b1; cpu_store = 1'b1; cpu_storetype = 2'b00; cpu_addr = 32'h30;
        dma_req = 1'b1;
        repeat (2) @(posedge clock);
        #3;
        chk("rst_mem_store", 32'(mem_store), 32'd0);
        chk("rst_cpu_stall", 32'(cpu_stall), 32'd0);
        cpu_req = 1'b0;
        #1;
        chk("rst_dma_gnt", 32'(dma_gnt), 32'd0);
        chk("rst_dma_rvalid", 32'(dma_rvalid), 32'd0);
        chk("rst_dma_rdata", dma_rdata, 32'd0);
        next_cycle();
        drive_idle();
        reset_n = 1'b1;

        // DMA read on idle DMEM.
        next_cycle();
        dma_req = 1'b1; dma_we = 1'b0; dma_addr = 32'h0000_0013;
        #2;
        chk("rd_gnt", 32'(dma_gnt), 32'd1);
        chk("rd_mem_addr", mem_addr, 32'h10);
        chk("rd_storetype", 32'(mem_storetype), 32'd0);
        chk("rd_mem_store", 32'(mem_store), 32'd0);
        exp_q.push_back(32'h1000_0004);
        next_cycle();
        drive_idle();
        #2;
        chk("rd_rvalid", 32'(dma_rvalid), 32'd1);
        chk("idle_gnt", 32'(dma_gnt), 32'd0);
        chk("idle_storetype", 32'(mem_storetype), 32'd3);
        chk("idle_mem_addr", mem_addr, 32'd0);
        chk("idle_mem_wdata", mem_wdata, 32'd0);

        // CPU SB with a DMA write pending.
        next_cycle();
        cpu_req = 1'b1; cpu_store = 1'b1; cpu_storetype = 2'b10;
        cpu_addr = 32'h21; cpu_wdata = 32'h0000_00AB;
        dma_req = 1'b1; dma_we = 1'b1; dma_addr = 32'h40; dma_wdata = 32'hDEAD_BEEF;
        #2;
        chk("sb_storetype", 32'(mem_storetype), 32'd2);
        chk("sb_mem_addr", mem_addr, 32'h21);
        chk("sb_mem_wdata", mem_wdata, 32'hAB);
        chk("sb_mem_store", 32'(mem_store), 32'd1);
        chk("sb_dma_gnt", 32'(dma_gnt), 32'd0);
        chk("sb_cpu_stall", 32'(cpu_stall), 32'd0);
        next_cycle();
        cpu_req = 1'b0; cpu_store = 1'b0; cpu_storetype = 2'b11;
        #2;
        chk("dw_gnt", 32'(dma_gnt), 32'd1);
        chk("dw_mem_addr", mem_addr, 32'h40);
        chk("dw_mem_wdata", mem_wdata, 32'hDEAD_BEEF);
        chk("dw_mem_store", 32'(mem_store), 32'd1);
        chk("dw_storetype", 32'(mem_storetype), 32'd0);
        next_cycle();
        drive_idle();
        cpu_req = 1'b1; cpu_addr = 32'h20;
        #2;
        chk("cpu_load_sb", cpu_rdata, 32'h1000_AB08);
        chk("dw_no_rvalid", 32'(dma_rvalid), 32'd0);

        // DMA read-back of the written word, then a back-to-back read.
        next_cycle();
        drive_idle();
        dma_req = 1'b1; dma_addr = 32'h40;
        #2;
        chk("rb_gnt", 32'(dma_gnt), 32'd1);
        exp_q.push_back(32'hDEAD_BEEF);
        next_cycle();
        dma_addr = 32'h47;
        #2;
        chk("b2b_mem_addr", mem_addr, 32'h44);
        chk("b2b_rvalid1", 32'(dma_rvalid), 32'd1);
        exp_q.push_back(32'h1000_0011);
        next_cycle();
        drive_idle();
        #2;
        chk("b2b_rvalid2", 32'(dma_rvalid), 32'd1);

        // CPU and DMA requesting continuously.
        next_cycle();
        cpu_req = 1'b1; cpu_addr = 32'h0;
        dma_req = 1'b1; dma_we = 1'b0; dma_addr = 32'h8;
        for (int i = 0; i < (GUARD ? 10 : 100); i++) begin
            logic eg;
            eg = GUARD && ((i % (LIMIT + 1)) == LIMIT);
            if (i > 0) next_cycle();
            #2;
            chk($sformatf("starve_gnt_%0d", i), 32'(dma_gnt), 32'(eg));
            chk($sformatf("starve_stall_%0d", i), 32'(cpu_stall), 32'(eg));
            chk($sformatf("starve_addr_%0d", i), mem_addr, eg ? 32'h8 : 32'h0);
            if (eg) exp_q.push_back(32'h1000_0002);
        end
        next_cycle();
        drive_idle();

        // Reset asserted in the middle of a DMA read grant.
        next_cycle();
        dma_req = 1'b1; dma_addr = 32'h10;
        #2;
        chk("rr_gnt", 32'(dma_gnt), 32'd1);
        #1;
        reset_n = 1'b0;
        #1;
        chk("rr_gnt_forced", 32'(dma_gnt), 32'd0);
        chk("rr_rdata_clr", dma_rdata, 32'd0);
        dma_we = 1'b1;
        #1;
        chk("rr_mem_store", 32'(mem_store), 32'd0);
        next_cycle();
        chk("rr_rvalid", 32'(dma_rvalid), 32'd0);
        chk("rr_rdata", dma_rdata, 32'd0);
        drive_idle();
        next_cycle();
        reset_n = 1'b1;
        next_cycle();
        cpu_req = 1'b1; cpu_addr = 32'h4;
        dma_req = 1'b1; dma_addr = 32'h8;
        #2;
        chk("post_rst_stall", 32'(cpu_stall), 32'd0);
        chk("post_rst_gnt", 32'(dma_gnt), 32'd0);
        chk("post_rst_addr", mem_addr, 32'h4);
        next_cycle();
        drive_idle();

        repeat (3) next_cycle();
        chk("sb_drain", 32'(exp_q.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
